// File: rtl/demux_stream_1ton.sv
// Registered 1:N stream demultiplexer with one holding register per
// channel, all-or-nothing broadcast and a sticky out-of-range select flag.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8,
    parameter int SEL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   err_sel,
    input  logic                   err_clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);

    ch_state_e                    state_q [N_OUT];
    ch_state_e                    state_d [N_OUT];
    logic [N_OUT-1:0][WIDTH-1:0]  data_q;
    logic                         err_q;
    logic                         err_d;

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] pop;
    logic             sel_ok;
    logic             sel_free;
    logic             accept;

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    // A channel is free when empty or being drained this cycle.
    always_comb begin
        free     = ~out_valid | out_ready;
        pop      = out_valid & out_ready;
        sel_ok   = {1'b0, in_sel} < N_LIM;
        sel_free = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free = free[k];
            end
        end
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
        accept = in_valid & in_ready;
        load   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            load[k] = accept &
                      (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
        end
        err_d = (accept & ~in_bcast & ~sel_ok) | (err_q & ~err_clr);
    end

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            state_d[k] = state_q[k];
            unique case (state_q[k])
                EMPTY: if (load[k]) state_d[k] = FULL;
                FULL:  if (pop[k] && !load[k]) state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= EMPTY;
            end
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= state_d[k];
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
            err_q <= err_d;
        end
    end

    assign out_data = data_q;
    assign err_sel  = err_q;

endmodule
